uart_boot_loader: RTL and testbench

UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

---
 rtl/uart_boot_loader.sv | 360 ++++++++++++++++++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_boot_loader
//  Purpose  : Receives boot images over an 8N1 UART link and writes them into
//             one of several target memories while holding the system in
//             reset. A zero-length frame releases the system.
//             Optional feature macro: UART_BOOT_LOADER_CHECKSUM_EN adds a
//             trailing 8-bit additive checksum byte to every frame.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_boot_loader #(
    parameter int DataWidth  = 32,
    parameter int AddrWidth  = 12,
    parameter int NumTargets = 2
) (
    input  logic                                                clk_i,
    input  logic                                                rst_i,
    input  logic                                                rx_i,
    input  logic [15:0]                                         clks_per_bit_i,
    output logic                                                mem_req_o,
    input  logic                                                mem_gnt_i,
    output logic [((NumTargets > 1) ? $clog2(NumTargets) : 1)-1:0] mem_sel_o,
    output logic [AddrWidth-1:0]                                mem_addr_o,
    output logic [DataWidth-1:0]                                mem_wdata_o,
    output logic                                                sys_rst_o,
    output logic                                                done_o,
    output logic                                                err_o
);

    localparam int          c_SEL_W      = (NumTargets > 1) ? $clog2(NumTargets) : 1;
    localparam int          c_BYTES      = DataWidth / 8;
    localparam logic [2:0]  c_LAST_BIDX  = 3'(c_BYTES - 1);
    localparam logic [7:0]  c_NUM_TGT    = 8'(NumTargets);
    localparam logic [17:0] c_ADDR_SPACE = 18'd1 << AddrWidth;
    localparam logic [7:0]  c_SYNC_BYTE  = 8'hA5;

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    rx_state_t   r_rx_st;
    logic        r_rx_s1;
    logic        r_rx_s2;
    logic        r_rx_prev;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shreg;
    logic [7:0]  r_byte;
    logic        r_byte_vld;
    logic        r_frame_err;

    logic [15:0] w_half;
    logic [15:0] w_full;

    assign w_half = {1'b0, clks_per_bit_i[15:1]} - 16'd1;
    assign w_full = clks_per_bit_i - 16'd1;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= rx_i;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // Bit-timing engine: mid-start check, full-bit data sampling, stop check
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_st     <= RX_IDLE;
            r_cnt       <= 16'd0;
            r_bit       <= 3'd0;
            r_shreg     <= 8'd0;
            r_byte      <= 8'd0;
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_rx_st)
                RX_IDLE: begin
                    r_cnt <= 16'd0;
                    if (r_rx_prev && !r_rx_s2) begin
                        r_rx_st <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_cnt == w_half) begin
                        r_cnt   <= 16'd0;
                        r_bit   <= 3'd0;
                        // A line back high at mid-start is a glitch: drop it quietly
                        r_rx_st <= r_rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == w_full) begin
                        r_cnt   <= 16'd0;
                        r_shreg <= {r_rx_s2, r_shreg[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_rx_st <= RX_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == w_full) begin
                        r_cnt   <= 16'd0;
                        r_rx_st <= RX_IDLE;
                        if (r_rx_s2) begin
                            r_byte     <= r_shreg;
                            r_byte_vld <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_rx_st <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame parser and memory write engine
    // ------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_TGT   = 4'd1,
        S_LEN0  = 4'd2,
        S_LEN1  = 4'd3,
        S_ADR0  = 4'd4,
        S_ADR1  = 4'd5,
        S_DATA  = 4'd6,
        S_WRITE = 4'd7,
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        S_CSUM  = 4'd8,
`endif
        S_DONE  = 4'd9,
        S_ERR   = 4'd10
    } state_t;

    state_t                r_state;
    logic [15:0]           r_len;
    logic [7:0]            r_addr_lo;
    logic [15:0]           r_words_left;
    logic [2:0]            r_bidx;
    logic [DataWidth-1:0]  r_word_buf;
    logic                  r_req;
    logic [c_SEL_W-1:0]    r_sel;
    logic [AddrWidth-1:0]  r_addr;
    logic [DataWidth-1:0]  r_wdata;
    logic                  r_sys_rst;
    logic                  r_done;
    logic                  r_err;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    logic [7:0]            r_sum;
    logic                  r_end;
`endif

    logic [15:0]          w_start;
    logic [17:0]          w_span;
    logic                 w_fits;
    logic                 w_grant;
    logic                 w_last_byte;
    logic [DataWidth-1:0] w_word;

    assign w_start     = {r_byte, r_addr_lo};
    assign w_span      = {2'b00, w_start} + {2'b00, r_len};
    assign w_fits      = (w_span <= c_ADDR_SPACE);
    assign w_grant     = r_req & mem_gnt_i;
    assign w_last_byte = (r_bidx == c_LAST_BIDX);

    // Current word with the just-received byte merged in (little-endian)
    always_comb begin
        w_word = r_word_buf;
        for (int i = 0; i < c_BYTES; i++) begin
            if (r_bidx == 3'(i)) begin
                w_word[i*8 +: 8] = r_byte;
            end
        end
    end

    // Main control FSM with registered memory-port and status outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_len        <= 16'd0;
            r_addr_lo    <= 8'd0;
            r_words_left <= 16'd0;
            r_bidx       <= 3'd0;
            r_word_buf   <= '0;
            r_req        <= 1'b0;
            r_sel        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_sys_rst    <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            r_sum        <= 8'd0;
            r_end        <= 1'b0;
`endif
        end else begin
            // Accepted write: retire the request and step to the next word
            if (w_grant) begin
                r_req  <= 1'b0;
                r_addr <= r_addr + 1'b1;
            end

            if (r_frame_err && (r_state != S_DONE) && (r_state != S_ERR)) begin
                r_state <= S_ERR;
                r_req   <= 1'b0;
                r_err   <= 1'b1;
            end else if (r_byte_vld) begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                r_sum <= r_sum + r_byte;
`endif
                case (r_state)
                    S_IDLE: begin
                        if (r_byte == c_SYNC_BYTE) begin
                            r_state <= S_TGT;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                            r_sum   <= 8'd0;
`endif
                        end
                    end
                    S_TGT: begin
                        if (r_byte >= c_NUM_TGT) begin
                            r_state <= S_ERR;
                            r_req   <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_sel   <= r_byte[c_SEL_W-1:0];
                            r_state <= S_LEN0;
                        end
                    end
                    S_LEN0: begin
                        r_len[7:0] <= r_byte;
                        r_state    <= S_LEN1;
                    end
                    S_LEN1: begin
                        r_len[15:8] <= r_byte;
                        r_state     <= S_ADR0;
                    end
                    S_ADR0: begin
                        r_addr_lo <= r_byte;
                        r_state   <= S_ADR1;
                    end
                    S_ADR1: begin
                        // Reject any frame that would run past the top of memory
                        if (!w_fits) begin
                            r_state <= S_ERR;
                            r_req   <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_addr       <= w_start[AddrWidth-1:0];
                            r_words_left <= r_len;
                            r_bidx       <= 3'd0;
                            if (r_len == 16'd0) begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                                r_end   <= 1'b1;
                                r_state <= S_CSUM;
`else
                                r_state   <= S_DONE;
                                r_done    <= 1'b1;
                                r_sys_rst <= 1'b0;
`endif
                            end else begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                                r_end   <= 1'b0;
`endif
                                r_state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (w_last_byte) begin
                            r_bidx <= 3'd0;
                            if (r_req && !mem_gnt_i) begin
                                // Previous word still waiting: memory too slow
                                r_state <= S_ERR;
                                r_req   <= 1'b0;
                                r_err   <= 1'b1;
                            end else begin
                                r_wdata      <= w_word;
                                r_req        <= 1'b1;
                                r_words_left <= r_words_left - 16'd1;
                                if (r_words_left == 16'd1) begin
                                    r_state <= S_WRITE;
                                end
                            end
                        end else begin
                            r_word_buf <= w_word;
                            r_bidx     <= r_bidx + 3'd1;
                        end
                    end
                    S_WRITE: begin
                        // A new byte before the last word is accepted is an overrun
                        r_state <= S_ERR;
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                    end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        if (r_byte != r_sum) begin
                            r_state <= S_ERR;
                            r_req   <= 1'b0;
                            r_err   <= 1'b1;
                        end else if (r_end) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_sys_rst <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
`endif
                    S_DONE: ;
                    S_ERR:  ;
                    default: begin
                        r_state <= S_ERR;
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                    end
                endcase
            end else if ((r_state == S_WRITE) && w_grant) begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                r_state <= S_CSUM;
`else
                r_state <= S_IDLE;
`endif
            end
        end
    end

    assign mem_req_o   = r_req;
    assign mem_sel_o   = r_sel;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign sys_rst_o   = r_sys_rst;
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_boot_loader
//  Purpose  : Randomized frame stimulus for uart_boot_loader, checked against
//             a transaction-level model (expected write queue + load status).
//             Honours UART_BOOT_LOADER_CHECKSUM_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_boot_loader;

    localparam int CPB = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        rx_i  = 1'b1;
    logic [15:0] clks_per_bit_i = 16'(CPB);
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b0;
    logic [0:0]  mem_sel_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        sys_rst_o;
    logic        done_o;
    logic        err_o;

    uart_boot_loader #(
        .DataWidth  (32),
        .AddrWidth  (12),
        .NumTargets (2)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rx_i           (rx_i),
        .clks_per_bit_i (clks_per_bit_i),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_sel_o      (mem_sel_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .sys_rst_o      (sys_rst_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [0:0]  sel;
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    int          tests = 0;
    int          fails = 0;
    wr_t         exp_q[$];
    wr_t         obs_log[$];
    logic [31:0] wq[$];
    int          mode   = 0;     // 0 loading, 1 done, 2 error
    bit          gnt_en = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            tick(CPB);
        end
        rx_i = !bad_stop;
        tick(CPB);
        rx_i = 1'b1;
        tick(4);
    endtask

    // Sends A5 + header + words in wq (+ checksum) and updates the model
    task automatic send_frame(input logic [7:0] tgt, input logic [15:0] len,
                              input logic [15:0] addr, input bit bad_csum);
        logic [7:0] bytes[$];
        logic [7:0] sum;
        bit         valid;
        bytes = {tgt, len[7:0], len[15:8], addr[7:0], addr[15:8]};
        foreach (wq[i]) begin
            for (int k = 0; k < 4; k++) bytes.push_back(wq[i][k*8 +: 8]);
        end
        sum = 8'd0;
        foreach (bytes[i]) sum = sum + bytes[i];
        valid = (mode == 0) && (tgt < 8'd2) && (int'(addr) + int'(len) <= 4096);
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        if (bad_csum) valid = 1'b0;
`endif
        if (valid && gnt_en) begin
            for (int i = 0; i < int'(len); i++) begin
                exp_q.push_back('{sel: tgt[0], addr: 12'(int'(addr) + i), data: wq[i]});
            end
        end
        send_byte(8'hA5, 1'b0);
        foreach (bytes[i]) send_byte(bytes[i], 1'b0);
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        send_byte(bad_csum ? (sum ^ 8'h01) : sum, 1'b0);
`endif
        if (mode == 0) begin
            if (!valid)                   mode = 2;
            else if (len == 16'd0)        mode = 1;
            else if (!gnt_en && len >= 2) mode = 2;  // second word overruns
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick(1);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        tick(4);
    endtask

    task automatic reset_pulse(input int cycles);
        rst_i = 1'b1;
        mode  = 0;
        exp_q.delete();
        obs_log.delete();
        tick(cycles);
        rst_i = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_req"},    64'(mem_req_o),   64'd0);
        check({pfx, "_sel"},    64'(mem_sel_o),   64'd0);
        check({pfx, "_addr"},   64'(mem_addr_o),  64'd0);
        check({pfx, "_wdata"},  64'(mem_wdata_o), 64'd0);
        check({pfx, "_sysrst"}, 64'(sys_rst_o),   64'd1);
        check({pfx, "_done"},   64'(done_o),      64'd0);
        check({pfx, "_err"},    64'(err_o),       64'd0);
    endtask

    // Memory-side grant generator (random back-pressure)
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            mem_gnt_i = gnt_en && ($urandom_range(0, 2) != 0);
        end
    end

    // Per-cycle comparison of DUT outputs against the model
    initial begin
        wr_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (mem_req_o && mem_gnt_i) begin
                    obs_log.push_back('{sel: mem_sel_o, addr: mem_addr_o, data: mem_wdata_o});
                    if (exp_q.size() == 0) begin
                        check("unexpected_write_addr", 64'(mem_addr_o), 64'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_sel",   64'(mem_sel_o),   64'(e.sel));
                        check("wr_addr",  64'(mem_addr_o),  64'(e.addr));
                        check("wr_wdata", 64'(mem_wdata_o), 64'(e.data));
                    end
                end
                check("done_vs_sysrst", 64'(done_o), 64'(!sys_rst_o));
                if (mode == 1) begin
                    check("done_state_req", 64'(mem_req_o), 64'd0);
                    check("done_state_err", 64'(err_o),     64'd0);
                end else if (mode == 2) begin
                    check("err_state_err",    64'(err_o),     64'd1);
                    check("err_state_req",    64'(mem_req_o), 64'd0);
                    check("err_state_sysrst", 64'(sys_rst_o), 64'd1);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  jb;
        logic [15:0] ln;
        logic [15:0] ad;

        // Reset values
        reset_pulse(3);
        @(negedge clk_i);
        check_reset_vals("reset");

        // Directed two-word frame with literal expectations
        wq = {32'h11223344, 32'h55667788};
        send_frame(8'h00, 16'd2, 16'h0010, 1'b0);
        wait_drain("t1_drain");
        check("t1_nwrites", 64'(obs_log.size()), 64'd2);
        if (obs_log.size() >= 2) begin
            check("t1_w0_addr", 64'(obs_log[0].addr), 64'h010);
            check("t1_w0_data", 64'(obs_log[0].data), 64'h11223344);
            check("t1_w1_addr", 64'(obs_log[1].addr), 64'h011);
            check("t1_w1_data", 64'(obs_log[1].data), 64'h55667788);
        end

        // Random frames with idle junk in between
        for (int f = 0; f < 5; f++) begin
            jb = 8'($urandom_range(0, 255));
            if (jb == 8'hA5) jb = 8'h5A;
            send_byte(jb, 1'b0);
            ln = 16'($urandom_range(1, 2));
            ad = 16'($urandom_range(0, 4096 - int'(ln)));
            wq.delete();
            for (int i = 0; i < int'(ln); i++) wq.push_back($urandom());
            send_frame(8'($urandom_range(0, 1)), ln, ad, 1'b0);
            wait_drain("rand_drain");
        end

        // Top-of-memory boundary: exactly fits
        obs_log.delete();
        wq = {32'hDEADBEEF, 32'hCAFEF00D};
        send_frame(8'h01, 16'd2, 16'h0FFE, 1'b0);
        wait_drain("edge_drain");
        check("edge_nwrites", 64'(obs_log.size()), 64'd2);
        if (obs_log.size() >= 2) begin
            check("edge_w1_addr", 64'(obs_log[1].addr), 64'hFFF);
            check("edge_w1_sel",  64'(obs_log[1].sel),  64'd1);
        end
        check("loading_sysrst", 64'(sys_rst_o), 64'd1);
        check("loading_done",   64'(done_o),    64'd0);

        // End frame releases the system; later frames produce nothing
        wq.delete();
        send_frame(8'h00, 16'd0, 16'h0000, 1'b0);
        check("end_done",   64'(done_o),    64'd1);
        check("end_sysrst", 64'(sys_rst_o), 64'd0);
        wq = {32'h01020304};
        send_frame(8'h00, 16'd1, 16'h0020, 1'b0);
        tick(20);
        check("after_done_req", 64'(mem_req_o), 64'd0);

        // Bad target
        reset_pulse(2);
        wq = {32'hAAAA5555};
        send_frame(8'h05, 16'd1, 16'h0000, 1'b0);
        check("badtgt_err",    64'(err_o),          64'd1);
        check("badtgt_sysrst", 64'(sys_rst_o),      64'd1);
        check("badtgt_writes", 64'(obs_log.size()), 64'd0);

        // Range overflow: 0xFFE + 4 > 4096
        reset_pulse(2);
        wq.delete();
        send_frame(8'h00, 16'd4, 16'h0FFE, 1'b0);
        check("ovf_err",    64'(err_o),          64'd1);
        check("ovf_writes", 64'(obs_log.size()), 64'd0);

        // Overrun: no grant across two completed words
        reset_pulse(2);
        gnt_en = 1'b0;
        wq = {32'h12345678, 32'h9ABCDEF0};
        send_frame(8'h00, 16'd2, 16'h0100, 1'b0);
        check("overrun_err", 64'(err_o),     64'd1);
        check("overrun_req", 64'(mem_req_o), 64'd0);
        gnt_en = 1'b1;

        // Framing error
        reset_pulse(2);
        send_byte(8'hA5, 1'b1);
        mode = 2;
        tick(2);
        check("framing_err", 64'(err_o), 64'd1);

        // Reset mid-data
        reset_pulse(2);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h40, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h66, 1'b0);
        rst_i = 1'b1;
        mode  = 0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_reset_vals("middata");

        // Reset while a request is pending
        gnt_en = 1'b0;
        wq = {32'h0BADF00D};
        send_frame(8'h01, 16'd1, 16'h0200, 1'b0);
        check("midreq_pending", 64'(mem_req_o), 64'd1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        gnt_en = 1'b1;
        @(negedge clk_i);
        check_reset_vals("midreq");

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        // End frame with a corrupted checksum
        reset_pulse(2);
        wq.delete();
        send_frame(8'h00, 16'd0, 16'h0000, 1'b1);
        check("badcsum_err",  64'(err_o),  64'd1);
        check("badcsum_done", 64'(done_o), 64'd0);
`endif

        tick(10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
